// File: rtl/hpu_sprite_fetch_if.sv
// Memory read port of the sprite fetcher: request/grant handshake with
// read data returned the cycle after a granted request.
interface hpu_sprite_fetch_if;
  logic        mem_req;
  logic        mem_gnt;
  logic [15:0] addr_out;
  logic [7:0]  data_in;

  modport master (output mem_req, output addr_out, input mem_gnt, input data_in);
  modport slave  (input mem_req, input addr_out, output mem_gnt, output data_in);
endinterface

// File: rtl/hpu_sprite_fetch.sv
// Per-line sprite evaluator/fetcher: scans OAM for next_line, fetches rows into
// shadow slots, promotes them on line_swap and composites them over the tile pixel.
module hpu_sprite_fetch #(
  parameter int unsigned NUM_ENGINES = 16,
  parameter int unsigned NUM_SPRITES = 64,
  parameter logic [15:0] OAM_BASE    = 16'hFE00,
  parameter logic [15:0] TILE_BASE   = 16'h8000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                line_start,
  input  logic [7:0]          next_line,
  input  logic                line_swap,
  input  logic [7:0]          column,
  input  logic [4:0]          tile_pixel_in,
  output logic [2:0]          pixel_out,
  output logic [1:0]          pallet_out,
  hpu_sprite_fetch_if.master  bus,
  output logic                busy,
  output logic                overflow
);

  localparam int unsigned EW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned CW = $clog2(NUM_ENGINES + 1);

  typedef enum logic [2:0] {IDLE, RD_Y, RD_X, RD_T, RD_A, RD_R0, RD_R1, RD_R2} state_t;

  typedef struct packed {
    logic        v;
    logic [7:0]  x;
    logic [1:0]  pal;
    logic        flip;
    logic [23:0] row;
  } slot_t;

  state_t         state_q, state_d;
  logic           dat_q, dat_d;
  logic [EW-1:0]  ent_q, ent_d;
  logic [7:0]     line_q, line_d;
  logic [7:0]     x_q, x_d;
  logic [7:0]     t_q, t_d;
  logic [2:0]     att_q, att_d;
  logic [2:0]     row_q, row_d;
  logic [7:0]     r0_q, r0_d;
  logic [7:0]     r1_q, r1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic [2:0]     pix_q, pix_d;
  logic [1:0]     pal_q, pal_d;
  slot_t          sh_q [NUM_ENGINES];
  slot_t          sh_d [NUM_ENGINES];
  slot_t          dp_q [NUM_ENGINES];
  slot_t          dp_d [NUM_ENGINES];

  logic           req;
  logic [15:0]    addr;

  // Scan/fetch sequencer; every read is a request phase then a data phase (dat_q).
  always_comb begin
    logic       next_entry;
    logic [7:0] diff;
    state_d    = state_q;
    dat_d      = dat_q;
    ent_d      = ent_q;
    line_d     = line_q;
    x_d        = x_q;
    t_d        = t_q;
    att_d      = att_q;
    row_d      = row_q;
    r0_d       = r0_q;
    r1_d       = r1_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    sh_d       = sh_q;
    dp_d       = dp_q;
    next_entry = 1'b0;
    diff       = line_q - bus.data_in;

    // Swap reads the pre-update shadow, so a coincident line_start still hands over the old line.
    if (line_swap) dp_d = sh_q;

    if (line_start) begin
      state_d = RD_Y;
      dat_d   = 1'b0;
      ent_d   = '0;
      line_d  = next_line;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      sh_d    = '{default: '0};
    end else if (state_q != IDLE) begin
      if (!dat_q) begin
        if (bus.mem_gnt) dat_d = 1'b1;
      end else begin
        dat_d = 1'b0;
        unique case (state_q)
          RD_Y: begin
            if (diff < 8'd8) begin
              row_d   = diff[2:0];
              state_d = RD_X;
            end else begin
              next_entry = 1'b1;
            end
          end
          RD_X: begin
            x_d     = bus.data_in;
            state_d = RD_T;
          end
          RD_T: begin
            t_d     = bus.data_in;
            state_d = RD_A;
          end
          RD_A: begin
            att_d = bus.data_in[2:0];
            if (!bus.data_in[7]) begin
              next_entry = 1'b1;
            end else if (cnt_q == CW'(NUM_ENGINES)) begin
              ovf_d   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = RD_R0;
            end
          end
          RD_R0: begin
            r0_d    = bus.data_in;
            state_d = RD_R1;
          end
          RD_R1: begin
            r1_d    = bus.data_in;
            state_d = RD_R2;
          end
          RD_R2: begin
            for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
              if (CW'(k) == cnt_q) begin
                sh_d[k] = '{v: 1'b1, x: x_q, pal: att_q[1:0], flip: att_q[2],
                            row: {bus.data_in, r1_q, r0_q}};
              end
            end
            cnt_d      = cnt_q + 1'b1;
            next_entry = 1'b1;
          end
          default: ;
        endcase
        if (next_entry) begin
          if (ent_q == EW'(NUM_SPRITES - 1)) begin
            state_d = IDLE;
          end else begin
            ent_d   = ent_q + 1'b1;
            state_d = RD_Y;
          end
        end
      end
    end
  end

  always_comb begin
    logic [15:0] oam_a;
    logic [15:0] row_a;
    oam_a = OAM_BASE + (16'(ent_q) << 2);
    row_a = TILE_BASE + 16'(t_q) * 16'd24 + 16'(row_q) * 16'd3;
    req   = (state_q != IDLE) && !dat_q;
    addr  = '0;
    if (req) begin
      unique case (state_q)
        RD_Y:    addr = oam_a;
        RD_X:    addr = oam_a + 16'd1;
        RD_T:    addr = oam_a + 16'd2;
        RD_A:    addr = oam_a + 16'd3;
        RD_R0:   addr = row_a;
        RD_R1:   addr = row_a + 16'd1;
        RD_R2:   addr = row_a + 16'd2;
        default: addr = '0;
      endcase
    end
  end

  // Lowest-numbered valid slot with an opaque pixel at this column wins.
  always_comb begin
    logic       found;
    logic [7:0] dx;
    logic [2:0] pidx;
    logic [2:0] spx;
    found = 1'b0;
    dx    = '0;
    pidx  = '0;
    spx   = '0;
    pix_d = tile_pixel_in[2:0];
    pal_d = tile_pixel_in[4:3];
    for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
      dx   = column - dp_q[k].x;
      pidx = dp_q[k].flip ? ~dx[2:0] : dx[2:0];
      spx  = 3'(dp_q[k].row >> (5'(pidx) * 5'd3));
      if (!found && dp_q[k].v && dx < 8'd8 && spx != 3'd0) begin
        found = 1'b1;
        pix_d = spx;
        pal_d = dp_q[k].pal;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dat_q   <= 1'b0;
      ent_q   <= '0;
      line_q  <= '0;
      x_q     <= '0;
      t_q     <= '0;
      att_q   <= '0;
      row_q   <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pix_q   <= '0;
      pal_q   <= '0;
      sh_q    <= '{default: '0};
      dp_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      ent_q   <= ent_d;
      line_q  <= line_d;
      x_q     <= x_d;
      t_q     <= t_d;
      att_q   <= att_d;
      row_q   <= row_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pix_q   <= pix_d;
      pal_q   <= pal_d;
      sh_q    <= sh_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.mem_req  = req;
  assign bus.addr_out = addr;
  assign pixel_out    = pix_q;
  assign pallet_out   = pal_q;
  assign busy         = (state_q != IDLE);
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_hpu_sprite_fetch.sv
// Scoreboard bench for hpu_sprite_fetch: byte-memory slave, address and pixel
// expectations queued by the stimulus and checked by independent monitors.
module tb_hpu_sprite_fetch;
  logic       clk = 1'b0;
  logic       reset;
  logic       line_start;
  logic [7:0] next_line;
  logic       line_swap;
  logic [7:0] column;
  logic [4:0] tile_pixel_in;
  logic [2:0] pixel_out;
  logic [1:0] pallet_out;
  logic       busy;
  logic       overflow;

  hpu_sprite_fetch_if bus ();

  hpu_sprite_fetch #(
    .NUM_ENGINES(16),
    .NUM_SPRITES(64),
    .OAM_BASE   (16'hFE00),
    .TILE_BASE  (16'h8000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .line_start   (line_start),
    .next_line    (next_line),
    .line_swap    (line_swap),
    .column       (column),
    .tile_pixel_in(tile_pixel_in),
    .pixel_out    (pixel_out),
    .pallet_out   (pallet_out),
    .bus          (bus),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] aq [$];
  bit          achk = 1'b0;
  logic [4:0]  pq [$];
  logic [7:0]  cq [$];
  bit          pv = 1'b0;
  logic [2:0]  ex [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Memory slave and address monitor.
  initial begin
    logic        r, g;
    logic [15:0] a, e;
    forever begin
      @(posedge clk);
      r = bus.mem_req;
      g = bus.mem_gnt;
      a = bus.addr_out;
      #1;
      if (r === 1'b1 && g === 1'b1) begin
        bus.data_in = mem[a];
        if (achk) begin
          if (aq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL addr extra: got %h want none", a);
          end else begin
            e = aq.pop_front();
            check("addr seq", 32'(a), 32'(e));
          end
        end
      end
    end
  end

  // Pixel monitor: one-cycle latency from column to registered output.
  initial begin
    bit         s;
    logic [4:0] e;
    logic [7:0] c;
    forever begin
      @(posedge clk);
      s = pv;
      #1;
      if (s) begin
        if (pq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pix underflow: got %h want none", {pallet_out, pixel_out});
        end else begin
          e = pq.pop_front();
          c = cq.pop_front();
          check($sformatf("pix col %0d", c), 32'({pallet_out, pixel_out}), 32'(e));
        end
      end
    end
  end

  task automatic pix(input logic [7:0] col, input logic [4:0] tile, input logic [4:0] exp);
    @(negedge clk);
    column        = col;
    tile_pixel_in = tile;
    pq.push_back(exp);
    cq.push_back(col);
    pv = 1'b1;
  endtask

  task automatic pix_end();
    @(negedge clk);
    pv = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_oam();
    for (int n = 0; n < 64; n++) begin
      mem[16'hFE00 + 4*n]     = 8'd200;
      mem[16'hFE00 + 4*n + 1] = 8'd0;
      mem[16'hFE00 + 4*n + 2] = 8'd0;
      mem[16'hFE00 + 4*n + 3] = 8'd0;
    end
  endtask

  task automatic scan(input logic [7:0] ln);
    @(negedge clk);
    next_line  = ln;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic swap();
    @(negedge clk);
    line_swap = 1'b1;
    @(negedge clk);
    line_swap = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 3000; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    check(nm, 32'(busy), 32'd0);
  endtask

  task automatic push_rest_y();
    for (int n = 1; n < 64; n++) aq.push_back(16'(16'hFE00 + 4*n));
  endtask

  initial begin
    reset         = 1'b1;
    line_start    = 1'b0;
    next_line     = '0;
    line_swap     = 1'b0;
    column        = '0;
    tile_pixel_in = '0;
    bus.mem_gnt   = 1'b1;
    bus.data_in   = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    clear_oam();

    repeat (2) @(negedge clk);
    check("rst mem_req", 32'(bus.mem_req), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst addr", 32'(bus.addr_out), 32'd0);
    check("rst pix", 32'({pallet_out, pixel_out}), 32'd0);
    reset = 1'b0;

    // Basic sprite: row 2 of tile 1 lives at 8000+24+6 = 801E..8020, pixels 1,2,3,4,5,6,7,1.
    mem[16'hFE00] = 8'd10; mem[16'hFE01] = 8'd20; mem[16'hFE02] = 8'd1; mem[16'hFE03] = 8'h81;
    mem[16'h801E] = 8'hD1; mem[16'h801F] = 8'h58; mem[16'h8020] = 8'h3F;
    for (int i = 0; i < 4; i++) aq.push_back(16'(16'hFE00 + i));
    for (int i = 0; i < 3; i++) aq.push_back(16'(16'h801E + i));
    push_rest_y();
    achk = 1'b1;
    scan(8'd12);
    wait_idle("basic idle");
    achk = 1'b0;
    check("basic addr left", 32'(aq.size()), 32'd0);
    check("basic overflow", 32'(overflow), 32'd0);
    swap();
    pix(8'd19, 5'b10011, 5'b10011);
    for (int i = 0; i < 8; i++) pix(8'(20 + i), 5'b10011, {2'b01, ex[i]});
    pix(8'd28, 5'b10011, 5'b10011);
    pix_end();

    // Horizontal flip.
    mem[16'hFE03] = 8'h85;
    scan(8'd12);
    wait_idle("flip idle");
    swap();
    for (int i = 0; i < 8; i++) pix(8'(20 + i), 5'b10011, {2'b01, ex[7 - i]});
    pix_end();

    // Overlap: slot0 px0=0 px1=3 (pal 2), slot1 px0=5 px1=6 (pal 3).
    clear_oam();
    mem[16'hFE00] = 8'd10; mem[16'hFE01] = 8'd50; mem[16'hFE02] = 8'd2; mem[16'hFE03] = 8'h82;
    mem[16'hFE04] = 8'd10; mem[16'hFE05] = 8'd50; mem[16'hFE06] = 8'd3; mem[16'hFE07] = 8'h83;
    mem[16'h8036] = 8'h18; mem[16'h8037] = 8'h00; mem[16'h8038] = 8'h00;
    mem[16'h804E] = 8'h35; mem[16'h804F] = 8'h00; mem[16'h8050] = 8'h00;
    scan(8'd12);
    wait_idle("overlap idle");
    swap();
    pix(8'd49, 5'b00100, 5'b00100);
    pix(8'd50, 5'b00100, 5'b11101);
    pix(8'd51, 5'b00100, 5'b10011);
    pix(8'd52, 5'b00100, 5'b00100);
    pix_end();

    // Overflow: 17 hitting sprites, row 3 of tile 0 (8009..800B) all pixel 7.
    clear_oam();
    for (int n = 0; n < 17; n++) begin
      mem[16'hFE00 + 4*n]     = 8'd0;
      mem[16'hFE00 + 4*n + 1] = 8'(8*n);
      mem[16'hFE00 + 4*n + 2] = 8'd0;
      mem[16'hFE00 + 4*n + 3] = 8'h80;
    end
    mem[16'h8009] = 8'hFF; mem[16'h800A] = 8'hFF; mem[16'h800B] = 8'hFF;
    scan(8'd3);
    wait_idle("ovf idle");
    check("ovf flag", 32'(overflow), 32'd1);
    swap();
    pix(8'd0,   5'b01001, 5'b00111);
    pix(8'd120, 5'b01001, 5'b00111);
    pix(8'd127, 5'b01001, 5'b00111);
    pix(8'd128, 5'b01001, 5'b01001);
    pix_end();

    // Wrap: Y=FE, line 1 -> row 3 of tile 4 at 8069..806B; grant withheld 5 cycles.
    clear_oam();
    mem[16'hFE00] = 8'hFE; mem[16'hFE01] = 8'd100; mem[16'hFE02] = 8'd4; mem[16'hFE03] = 8'h80;
    mem[16'h8069] = 8'h02; mem[16'h806A] = 8'h00; mem[16'h806B] = 8'h00;
    for (int i = 0; i < 4; i++) aq.push_back(16'(16'hFE00 + i));
    for (int i = 0; i < 3; i++) aq.push_back(16'(16'h8069 + i));
    push_rest_y();
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    achk = 1'b1;
    scan(8'd1);
    check("ovf cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("stall req", 32'(bus.mem_req), 32'd1);
      check("stall addr", 32'(bus.addr_out), 32'hFE00);
      @(negedge clk);
    end
    bus.mem_gnt = 1'b1;
    wait_idle("wrap idle");
    achk = 1'b0;
    check("wrap addr left", 32'(aq.size()), 32'd0);
    swap();
    pix(8'd99,  5'b11111, 5'b11111);
    pix(8'd100, 5'b11111, 5'b00010);
    pix(8'd101, 5'b11111, 5'b11111);
    pix_end();

    // Reset in the middle of a fetch.
    scan(8'd1);
    repeat (3) @(negedge clk);
    check("mid busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mrst mem_req", 32'(bus.mem_req), 32'd0);
    check("mrst busy", 32'(busy), 32'd0);
    check("mrst addr", 32'(bus.addr_out), 32'd0);
    check("mrst pix", 32'({pallet_out, pixel_out}), 32'd0);
    reset = 1'b0;
    swap();
    pix(8'd100, 5'b11111, 5'b11111);
    pix_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
